// File: rtl/bmc_rx_framer.sv
// Oversampling BMC receive framer: recovers half-bit timing from line edges, hunts for
// the BMC-violating preamble and hands 48 captured half-bit cells to the decoder.
module bmc_rx_framer #(
  parameter int SAMPLES_PER_HALFBIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic        valid_out,
  output logic [47:0] o_block,
  output logic        frame_err
);
  localparam int PH_W = $clog2(SAMPLES_PER_HALFBIT);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_HALFBIT - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(SAMPLES_PER_HALFBIT / 2);

  typedef enum logic {HUNT, DATA} state_t;
  state_t state, state_nxt;

  logic            rx_meta, rx_s, rx_d;
  logic            rx_edge, strobe, hb;
  logic [PH_W-1:0] ph;
  logic [5:0]      pre, pre_nxt, pre_shift;
  logic [5:0]      cnt, cnt_nxt;
  logic [47:0]     sh, sh_nxt, block_nxt;
  logic            last, last_nxt;
  logic            valid_nxt, err_nxt;

  // Stage: line synchronizer, edge detect and half-bit phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_d    <= 1'b0;
      ph      <= '0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      if (rx_edge || ph == PH_LAST) ph <= '0;
      else                          ph <= ph + 1'b1;
    end
  end

  assign rx_edge   = rx_s ^ rx_d;
  assign strobe    = (ph == PH_MID) && !rx_edge;
  assign hb        = rx_s;
  assign pre_shift = {pre[4:0], hb};

  // Stage: preamble hunt and cell capture, decided on each strobe
  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    last_nxt  = last;
    block_nxt = o_block;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      HUNT: begin
        if (strobe) begin
          pre_nxt = pre_shift;
          if (pre_shift == 6'b111000 || pre_shift == 6'b000111) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            last_nxt  = hb;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          sh_nxt   = {sh[46:0], hb};
          last_nxt = hb;
          // Even cells open a bit and must flip relative to the cell before them
          if (!cnt[0] && (hb == last)) begin
            err_nxt   = 1'b1;
            pre_nxt   = '0;
            state_nxt = HUNT;
          end else if (cnt == 6'd47) begin
            block_nxt = {sh[46:0], hb};
            valid_nxt = 1'b1;
            pre_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Stage: framer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      pre       <= '0;
      cnt       <= '0;
      sh        <= '0;
      last      <= 1'b0;
      o_block   <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      cnt       <= cnt_nxt;
      sh        <= sh_nxt;
      last      <= last_nxt;
      o_block   <= block_nxt;
      valid_out <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bmc_rx_framer.sv
// Bench for bmc_rx_framer: drives half-bit cell streams and checks frame/error events
// against a cell-level reference scan of the same stream.
module tb_bmc_rx_framer;
  localparam int SPH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_in = 1'b0;
  logic        valid_out, frame_err;
  logic [47:0] o_block;

  bmc_rx_framer #(.SAMPLES_PER_HALFBIT(SPH)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .valid_out(valid_out), .o_block(o_block), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [47:0] blk;
    int          cyc;
  } ev_t;

  ev_t         act_q[$];
  ev_t         exp_q[$];
  ev_t         mon_e;
  bit          glitch_en = 1'b0;
  int          both_hi = 0;
  int          blk_glitch = 0;
  logic [47:0] prev_blk;

  // Output monitor: records every pulse with its cycle, flags overlap and stray block changes
  always @(negedge clk) begin
    if (valid_out === 1'b1 && frame_err === 1'b1) both_hi++;
    if (glitch_en && o_block !== prev_blk && valid_out !== 1'b1) blk_glitch++;
    if (valid_out === 1'b1 || frame_err === 1'b1) begin
      mon_e.err = (frame_err === 1'b1);
      mon_e.blk = o_block;
      mon_e.cyc = cyc;
      act_q.push_back(mon_e);
    end
    prev_blk = o_block;
  end

  // Stimulus state: cell stream, per-cell strobe cycle, run tracking for timing
  bit          cells[$];
  int          stb[$];
  bit          jit_en = 1'b0;
  bit          drv_prev = 1'b0;
  int          run_k = 0;
  logic [47:0] exp_last_good = '0;

  function automatic logic [47:0] bmc48(input logic [23:0] d, input bit last_in);
    logic [47:0] r;
    bit c, l;
    r = '0;
    l = last_in;
    for (int b = 23; b >= 0; b--) begin
      c = ~l;
      r = {r[46:0], c};
      if (d[b]) c = ~c;
      r = {r[46:0], c};
      l = c;
    end
    return r;
  endfunction

  task automatic add_preface(input bit pol);
    for (int k = 0; k < 6; k++) cells.push_back(pol ? (k % 2 == 0) : (k % 2 == 1));
  endtask

  task automatic add_frame(input bit pol, input logic [23:0] d);
    logic [5:0]  pat;
    logic [47:0] r;
    pat = pol ? 6'b111000 : 6'b000111;
    for (int b = 5; b >= 0; b--) cells.push_back(pat[b]);
    r = bmc48(d, ~pol);
    for (int b = 47; b >= 0; b--) cells.push_back(r[b]);
  endtask

  // Each cell is SPH cycles, optionally one late (jitter) when that cannot add a strobe
  task automatic drive_seg();
    int off, len;
    stb.delete();
    foreach (cells[i]) begin
      @(negedge clk);
      if (cells[i] != drv_prev) run_k = cyc;
      off = cyc - run_k;
      len = SPH;
      if (jit_en && (off % SPH) <= 2 && $urandom_range(0, 1) == 1) len = SPH + 1;
      stb.push_back(run_k + 6 + SPH * (off / SPH));
      rx_in = cells[i];
      drv_prev = cells[i];
      repeat (len - 1) @(negedge clk);
    end
  endtask

  // Reference: scan the cell stream for a preamble, then judge the next 48 cells
  task automatic run_model();
    int          i, j, n;
    bit [5:0]    win;
    logic [47:0] blk;
    bit          done;
    ev_t         e;
    exp_q.delete();
    n = cells.size();
    i = 0;
    win = '0;
    while (i < n) begin
      win = {win[4:0], cells[i]};
      i++;
      if (win == 6'b111000 || win == 6'b000111) begin
        win = '0;
        blk = '0;
        done = 1'b0;
        j = 0;
        while (!done && j < 48 && i + j < n) begin
          if (j % 2 == 0 && cells[i + j] == cells[i + j - 1]) begin
            e.err = 1'b1; e.blk = exp_last_good; e.cyc = stb[i + j];
            exp_q.push_back(e);
            done = 1'b1;
          end else begin
            blk = {blk[46:0], cells[i + j]};
          end
          j++;
        end
        if (!done && j == 48) begin
          e.err = 1'b0; e.blk = blk; e.cyc = stb[i + 47];
          exp_q.push_back(e);
          exp_last_good = blk;
        end
        i += j;
      end
    end
  endtask

  task automatic play();
    act_q.delete();
    if (cells[cells.size() - 1] == 1'b1) cells.push_back(1'b0);
    drive_seg();
    run_model();
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", k, valid_out); end
      total++;
      if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", k, frame_err); end
      total++;
      if (o_block !== 48'h0) begin bad++; $display("FAIL reset_block[%0d]: got %h want 0", k, o_block); end
      rx_in = (k == 0);
      if (k == 1) rst = 1'b0;
    end
    rx_in = 1'b0;
    repeat (6) @(negedge clk);
    drv_prev = 1'b0;
    run_k = cyc;
    glitch_en = 1'b1;
  endtask

  task automatic test_good_frame();
    cells.delete();
    jit_en = 1'b0;
    add_preface(1'b1);
    add_frame(1'b1, 24'hA5C3F0);
    play();
    total++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL good_count: got %0d events want 1 (model %0d)", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (act_q[k].err !== exp_q[k].err || act_q[k].blk !== exp_q[k].blk || act_q[k].cyc != exp_q[k].cyc) begin
        bad++; $display("FAIL good_ev%0d: got err=%0b blk=%h cyc=%0d want err=%0b blk=%h cyc=%0d", k,
                        act_q[k].err, act_q[k].blk, act_q[k].cyc, exp_q[k].err, exp_q[k].blk, exp_q[k].cyc);
      end
    end
    total++;
    if (o_block !== bmc48(24'hA5C3F0, 1'b0)) begin
      bad++; $display("FAIL good_block: got %h want %h", o_block, bmc48(24'hA5C3F0, 1'b0));
    end
  endtask

  task automatic test_inverted();
    logic [47:0] good_blk;
    good_blk = bmc48(24'hA5C3F0, 1'b0);
    cells.delete();
    jit_en = 1'b0;
    add_preface(1'b1);
    add_frame(1'b1, 24'hA5C3F0);
    foreach (cells[i]) cells[i] = ~cells[i];
    play();
    total++;
    if (act_q.size() != exp_q.size() || exp_q.size() != 1) begin
      bad++; $display("FAIL inv_count: got %0d events want 1 (model %0d)", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (act_q[k].err !== exp_q[k].err || act_q[k].blk !== exp_q[k].blk || act_q[k].cyc != exp_q[k].cyc) begin
        bad++; $display("FAIL inv_ev%0d: got err=%0b blk=%h cyc=%0d want err=%0b blk=%h cyc=%0d", k,
                        act_q[k].err, act_q[k].blk, act_q[k].cyc, exp_q[k].err, exp_q[k].blk, exp_q[k].cyc);
      end
    end
    total++;
    if (o_block !== ~good_blk) begin bad++; $display("FAIL inv_block: got %h want %h", o_block, ~good_blk); end
  endtask

  task automatic test_violation();
    logic [47:0] held;
    held = o_block;
    cells.delete();
    jit_en = 1'b0;
    add_preface(1'b1);
    add_frame(1'b1, 24'($urandom));
    cells[22] = cells[21];
    while (cells.size() > 23) void'(cells.pop_back());
    play();
    total++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL viol_count: got %0d events want 1 (model %0d)", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (act_q[k].err !== exp_q[k].err || act_q[k].blk !== exp_q[k].blk || act_q[k].cyc != exp_q[k].cyc) begin
        bad++; $display("FAIL viol_ev%0d: got err=%0b blk=%h cyc=%0d want err=%0b blk=%h cyc=%0d", k,
                        act_q[k].err, act_q[k].blk, act_q[k].cyc, exp_q[k].err, exp_q[k].blk, exp_q[k].cyc);
      end
    end
    total++;
    if (o_block !== held) begin bad++; $display("FAIL viol_block: got %h want %h", o_block, held); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d1, d2;
    d1 = 24'($urandom);
    d2 = 24'($urandom);
    cells.delete();
    jit_en = 1'b1;
    add_preface(1'b0);
    add_frame(1'b0, d1);
    add_frame(1'b0, d2);
    play();
    jit_en = 1'b0;
    total++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d events want 2 (model %0d)", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (act_q[k].err !== exp_q[k].err || act_q[k].blk !== exp_q[k].blk || act_q[k].cyc != exp_q[k].cyc) begin
        bad++; $display("FAIL b2b_ev%0d: got err=%0b blk=%h cyc=%0d want err=%0b blk=%h cyc=%0d", k,
                        act_q[k].err, act_q[k].blk, act_q[k].cyc, exp_q[k].err, exp_q[k].blk, exp_q[k].cyc);
      end
    end
    if (act_q.size() == 2) begin
      total++;
      if (act_q[0].blk !== bmc48(d1, 1'b1)) begin
        bad++; $display("FAIL b2b_block0: got %h want %h", act_q[0].blk, bmc48(d1, 1'b1));
      end
      total++;
      if (act_q[1].blk !== bmc48(d2, 1'b1)) begin
        bad++; $display("FAIL b2b_block1: got %h want %h", act_q[1].blk, bmc48(d2, 1'b1));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] d1, d2;
    bit          c30;
    d1 = 24'($urandom);
    d2 = 24'($urandom);
    cells.delete();
    add_preface(1'b1);
    add_frame(1'b1, d1);
    c30 = cells[42];
    while (cells.size() > 42) void'(cells.pop_back());
    act_q.delete();
    drive_seg();
    run_model();
    @(negedge clk);
    rx_in = c30;
    rst = 1'b1;
    glitch_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_in = 1'b0;
    repeat (6) @(negedge clk);
    drv_prev = 1'b0;
    run_k = cyc;
    exp_last_good = '0;
    glitch_en = 1'b1;
    total++;
    if (act_q.size() != 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL rst_partial: got %0d events want 0 (model %0d)", act_q.size(), exp_q.size());
    end
    total++;
    if (o_block !== 48'h0) begin bad++; $display("FAIL rst_block: got %h want 0", o_block); end
    cells.delete();
    add_preface(1'b1);
    add_frame(1'b1, d2);
    play();
    total++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      bad++; $display("FAIL rst_count: got %0d events want 1 (model %0d)", act_q.size(), exp_q.size());
    end
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (act_q[k].err !== exp_q[k].err || act_q[k].blk !== exp_q[k].blk || act_q[k].cyc != exp_q[k].cyc) begin
        bad++; $display("FAIL rst_ev%0d: got err=%0b blk=%h cyc=%0d want err=%0b blk=%h cyc=%0d", k,
                        act_q[k].err, act_q[k].blk, act_q[k].cyc, exp_q[k].err, exp_q[k].blk, exp_q[k].cyc);
      end
    end
    total++;
    if (o_block !== bmc48(d2, 1'b0)) begin bad++; $display("FAIL rst_block2: got %h want %h", o_block, bmc48(d2, 1'b0)); end
  endtask

  task automatic test_invariants();
    total++;
    if (both_hi != 0) begin bad++; $display("FAIL overlap: got %0d cycles with both pulses want 0", both_hi); end
    total++;
    if (blk_glitch != 0) begin bad++; $display("FAIL block_hold: got %0d stray o_block changes want 0", blk_glitch); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_inverted();
    test_violation();
    test_back_to_back();
    test_mid_reset();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
